// File: rtl/flash_burst_sequencer.sv
// Splits flash-space CPU transfers into 16-bit word cycles with one FL_TSn strobe per word.
// Latency: read word period 5 clocks, writes +1 per beat; gates write beats on FLASH_RDY, times out to TEA.
module flash_burst_sequencer #(
  parameter int RDY_TIMEOUT = 40000,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLK40,
  input  logic        RESET,
  input  logic        TSn,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [23:1] A,
  input  logic        FLASH_SPACE,
  input  logic        FLASH_RDY,
  input  logic        FLASH_TACK,
  output logic        FL_TSn,
  output logic        FL_RnW,
  output logic [23:1] FL_A,
  output logic        CPU_TACK,
  output logic        CPU_TEA
);

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_LINE = 2'b11;
  localparam int RDY_W = $clog2(RDY_TIMEOUT + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(RDY_TIMEOUT - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RDYWAIT, START, WAIT_ACK, GAP1, GAP2, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [23:1]       a_lat;
  logic              rnw_lat;
  logic [1:0]        siz_lat;
  logic [2:0]        beat;
  logic [RDY_W-1:0]  rdy_cnt;
  logic [ACK_W-1:0]  ack_cnt;

  logic              cpu_req, line_write, last_beat, lw_end;
  logic              rdy_expire, ack_expire, tack_set, tea_set;
  logic [23:1]       addr_src;
  logic [1:0]        siz_src;
  logic              rnw_src;
  logic [2:0]        beat_src;

  // Line beats wrap the longword index modulo 4; bit 1 picks hi (0) then lo (1) word.
  function automatic logic [23:1] beat_addr(input logic [23:1] base,
                                            input logic [1:0]  siz,
                                            input logic [2:0]  b);
    logic [1:0] lw;
    beat_addr = base;
    lw = base[3:2] + b[2:1];
    case (siz)
      SIZ_LONG: beat_addr[1] = b[0];
      SIZ_LINE: begin
        beat_addr[3:2] = lw;
        beat_addr[1]   = b[0];
      end
      default: ;
    endcase
  endfunction

  always_comb begin
    cpu_req    = !TSn && FLASH_SPACE;
    line_write = !RnW && (SIZ == SIZ_LINE);
    case (siz_lat)
      SIZ_LONG: last_beat = (beat == 3'd1);
      SIZ_LINE: last_beat = (beat == 3'd7);
      default:  last_beat = 1'b1;
    endcase
    lw_end     = ((siz_lat == SIZ_LONG) || (siz_lat == SIZ_LINE)) ? beat[0] : 1'b1;
    rdy_expire = !FLASH_RDY && (rdy_cnt == RDY_LAST);
    ack_expire = !FLASH_TACK && (ack_cnt == ACK_LAST);
    // A read launches straight out of IDLE, before the latches hold the request.
    addr_src   = (state_q == IDLE) ? A    : a_lat;
    siz_src    = (state_q == IDLE) ? SIZ  : siz_lat;
    rnw_src    = (state_q == IDLE) ? RnW  : rnw_lat;
    beat_src   = (state_q == IDLE) ? 3'd0 : beat;
  end

  always_ff @(posedge CLK40) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (line_write) state_d = ERR;
          else if (!RnW)  state_d = RDYWAIT;
          else            state_d = START;
        end
      end
      RDYWAIT: begin
        if (FLASH_RDY)       state_d = START;
        else if (rdy_expire) state_d = ERR;
      end
      START:    state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (FLASH_TACK)      state_d = last_beat ? IDLE : GAP1;
        else if (ack_expire) state_d = ERR;
      end
      GAP1:     state_d = GAP2;
      GAP2:     state_d = rnw_lat ? START : RDYWAIT;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    FL_TSn   = (state_q != START);
    tack_set = (state_q == WAIT_ACK) && FLASH_TACK && lw_end;
    tea_set  = (state_q == ERR);
  end

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      FL_RnW   <= 1'b1;
      FL_A     <= '0;
      CPU_TACK <= 1'b0;
      CPU_TEA  <= 1'b0;
      a_lat    <= '0;
      rnw_lat  <= 1'b1;
      siz_lat  <= '0;
      beat     <= '0;
      rdy_cnt  <= '0;
      ack_cnt  <= '0;
    end else begin
      CPU_TACK <= tack_set;
      CPU_TEA  <= tea_set;
      if ((state_q == IDLE) && cpu_req) begin
        a_lat   <= A;
        rnw_lat <= RnW;
        siz_lat <= SIZ;
        beat    <= '0;
      end
      if (state_d == START) begin
        FL_A   <= beat_addr(addr_src, siz_src, beat_src);
        FL_RnW <= rnw_src;
      end
      if ((state_q == WAIT_ACK) && FLASH_TACK) beat <= beat + 3'd1;
      rdy_cnt <= ((state_q == RDYWAIT) && !FLASH_RDY) ? rdy_cnt + 1'b1 : '0;
      ack_cnt <= ((state_q == WAIT_ACK) && !FLASH_TACK) ? ack_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_flash_burst_sequencer.sv
// Directed bench for flash_burst_sequencer with a simple flash cycle machine model.
// Event times are recorded relative to E0, the edge that samples TSn.
module tb_flash_burst_sequencer;

  localparam int RDY_TO = 120;
  localparam int ACK_TO = 15;

  logic        CLK40 = 1'b0;
  logic        RESET = 1'b1;
  logic        TSn = 1'b1;
  logic        RnW = 1'b1;
  logic [1:0]  SIZ = 2'b00;
  logic [23:1] A = '0;
  logic        FLASH_SPACE = 1'b1;
  logic        FLASH_RDY = 1'b1;
  logic        FLASH_TACK = 1'b0;
  logic        FL_TSn, FL_RnW, CPU_TACK, CPU_TEA;
  logic [23:1] FL_A;

  flash_burst_sequencer #(.RDY_TIMEOUT(RDY_TO), .ACK_TIMEOUT(ACK_TO)) u_dut (
    .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .RnW(RnW), .SIZ(SIZ), .A(A),
    .FLASH_SPACE(FLASH_SPACE), .FLASH_RDY(FLASH_RDY), .FLASH_TACK(FLASH_TACK),
    .FL_TSn(FL_TSn), .FL_RnW(FL_RnW), .FL_A(FL_A),
    .CPU_TACK(CPU_TACK), .CPU_TEA(CPU_TEA)
  );

  always #5 CLK40 = ~CLK40;

  int cyc = 0;
  always @(posedge CLK40) cyc <= cyc + 1;

  int          ts_cyc[$];
  logic [23:1] ts_addr[$];
  logic        ts_rnw[$];
  int          tack_cyc[$];
  int          tea_cyc[$];

  always @(negedge CLK40) begin
    if (!FL_TSn) begin
      ts_cyc.push_back(cyc);
      ts_addr.push_back(FL_A);
      ts_rnw.push_back(FL_RnW);
    end
    if (CPU_TACK) tack_cyc.push_back(cyc);
    if (CPU_TEA)  tea_cyc.push_back(cyc);
  end

  // Flash machine: samples FL_TSn at E1, answers with TACK high E2..E3.
  bit tack_off = 1'b0;
  initial begin
    forever begin
      @(negedge CLK40);
      if (!FL_TSn && !tack_off) begin
        repeat (2) @(posedge CLK40);
        #1 FLASH_TACK = 1'b1;
        @(posedge CLK40);
        #1 FLASH_TACK = 1'b0;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int e0, b_ts, b_tack, b_tea;
  int exp_line[8] = '{4, 5, 6, 7, 0, 1, 2, 3};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK40);
    #1;
  endtask

  task automatic cpu_cycle(input logic rnw, input logic [1:0] siz, input logic [23:1] addr);
    b_ts   = ts_cyc.size();
    b_tack = tack_cyc.size();
    b_tea  = tea_cyc.size();
    TSn = 1'b0;
    RnW = rnw;
    SIZ = siz;
    A   = addr;
    @(posedge CLK40);
    #1;
    TSn = 1'b1;
    e0  = cyc;
  endtask

  function automatic int n_ts();   return ts_cyc.size() - b_ts;     endfunction
  function automatic int n_tack(); return tack_cyc.size() - b_tack; endfunction
  function automatic int n_tea();  return tea_cyc.size() - b_tea;   endfunction
  function automatic int ts_rel(input int i);   return ts_cyc[b_ts + i] - e0;     endfunction
  function automatic int ts_a(input int i);     return int'(ts_addr[b_ts + i]);   endfunction
  function automatic int tack_rel(input int i); return tack_cyc[b_tack + i] - e0; endfunction
  function automatic int tea_rel(input int i);  return tea_cyc[b_tea + i] - e0;   endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fl_tsn"},   int'(FL_TSn),   1);
    check({tag, "_fl_rnw"},   int'(FL_RnW),   1);
    check({tag, "_fl_a"},     int'(FL_A),     0);
    check({tag, "_cpu_tack"}, int'(CPU_TACK), 0);
    check({tag, "_cpu_tea"},  int'(CPU_TEA),  0);
  endtask

  initial begin
    idle(3);
    @(negedge CLK40);
    check_reset_outputs("reset");
    idle(1);
    RESET = 1'b0;
    idle(2);

    // Line read from byte 0x8: longword index 2 first, wrapping.
    cpu_cycle(1'b1, 2'b11, 23'h4);
    idle(45);
    check("line_rd_ts_n", n_ts(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("line_rd_addr%0d", i), ts_a(i), exp_line[i]);
      check($sformatf("line_rd_ts_at%0d", i), ts_rel(i), 5 * i);
    end
    check("line_rd_rnw", int'(ts_rnw[b_ts]), 1);
    check("line_rd_tack_n", n_tack(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("line_rd_tack_at%0d", i), tack_rel(i), 8 + 10 * i);
    check("line_rd_tea_n", n_tea(), 0);

    // Long write, flash ready throughout.
    cpu_cycle(1'b0, 2'b00, 23'h80);
    idle(20);
    check("long_wr_ts_n", n_ts(), 2);
    check("long_wr_ts0_at", ts_rel(0), 1);
    check("long_wr_ts1_at", ts_rel(1), 7);
    check("long_wr_addr0", ts_a(0), 'h80);
    check("long_wr_addr1", ts_a(1), 'h81);
    check("long_wr_rnw", int'(ts_rnw[b_ts]), 0);
    check("long_wr_tack_n", n_tack(), 1);
    check("long_wr_tack_at", tack_rel(0), 10);
    check("long_wr_tea_n", n_tea(), 0);

    // Word write while flash busy for 100 clocks.
    FLASH_RDY = 1'b0;
    cpu_cycle(1'b0, 2'b10, 23'h1234);
    idle(100);
    FLASH_RDY = 1'b1;
    idle(15);
    check("busy_wr_ts_n", n_ts(), 1);
    check("busy_wr_ts_at", ts_rel(0), 101);
    check("busy_wr_addr", ts_a(0), 'h1234);
    check("busy_wr_tack_n", n_tack(), 1);
    check("busy_wr_tack_at", tack_rel(0), 104);
    check("busy_wr_tea_n", n_tea(), 0);

    // Flash never ready: ready timeout.
    FLASH_RDY = 1'b0;
    cpu_cycle(1'b0, 2'b01, 23'h10);
    idle(RDY_TO + 10);
    FLASH_RDY = 1'b1;
    check("rdy_to_tea_n", n_tea(), 1);
    check("rdy_to_tea_at", tea_rel(0), RDY_TO + 1);
    check("rdy_to_ts_n", n_ts(), 0);
    check("rdy_to_tack_n", n_tack(), 0);

    // Line write is refused outright.
    cpu_cycle(1'b0, 2'b11, 23'h40);
    idle(10);
    check("line_wr_tea_n", n_tea(), 1);
    check("line_wr_tea_at", tea_rel(0), 1);
    check("line_wr_ts_n", n_ts(), 0);
    check("line_wr_tack_n", n_tack(), 0);

    // Byte read with no acknowledge, then a normal byte read.
    tack_off = 1'b1;
    cpu_cycle(1'b1, 2'b01, 23'h55);
    idle(25);
    tack_off = 1'b0;
    check("ack_to_ts_n", n_ts(), 1);
    check("ack_to_tea_n", n_tea(), 1);
    check("ack_to_tea_at", tea_rel(0), ACK_TO + 2);
    check("ack_to_tack_n", n_tack(), 0);
    cpu_cycle(1'b1, 2'b01, 23'h56);
    idle(10);
    check("after_to_addr", ts_a(0), 'h56);
    check("after_to_tack_n", n_tack(), 1);
    check("after_to_tack_at", tack_rel(0), 3);
    check("after_to_tea_n", n_tea(), 0);

    // Outside flash space: ignored.
    FLASH_SPACE = 1'b0;
    cpu_cycle(1'b1, 2'b10, 23'h9);
    FLASH_SPACE = 1'b1;
    idle(10);
    check("no_space_ts_n", n_ts(), 0);
    check("no_space_tack_n", n_tack(), 0);

    // Reset during WAIT_ACK of the fourth line beat.
    cpu_cycle(1'b1, 2'b11, 23'h4);
    idle(16);
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    @(negedge CLK40);
    check_reset_outputs("mid_rst");
    idle(30);
    check("mid_rst_ts_n", n_ts(), 4);
    check("mid_rst_tack_n", n_tack(), 1);
    check("mid_rst_tack_at", tack_rel(0), 8);
    check("mid_rst_tea_n", n_tea(), 0);
    cpu_cycle(1'b1, 2'b10, 23'h2222);
    idle(10);
    check("fresh_ts_n", n_ts(), 1);
    check("fresh_ts_at", ts_rel(0), 0);
    check("fresh_addr", ts_a(0), 'h2222);
    check("fresh_tack_at", tack_rel(0), 3);
    check("fresh_tea_n", n_tea(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_burst_sequencer.md
# flash_burst_sequencer

Sits between the 68040 bus-cycle front end and the flash cycle state machine in U409. It splits each CPU transfer that hits flash space into 16-bit flash word cycles and issues a one-clock start strobe per word. It waits for the flash cycle acknowledge, spaces the starts so the flash machine is back in idle, gates write beats on FLASH_RDY, and returns one acknowledge per completed CPU longword. Unsupported or stalled cycles end with a transfer-error pulse.

## Interface
Parameters:
- RDY_TIMEOUT, 40000: clocks allowed in RDYWAIT before error (1 ms at 40 MHz).
- ACK_TIMEOUT, 15: clocks allowed in WAIT_ACK before error.

Ports:
- CLK40  in  1  system clock. One clock domain.
- RESET  in  1  synchronous, active-high reset.
- TSn  in  1  CPU transfer start, active low.
- RnW  in  1  CPU read (1) / write (0).
- SIZ  in  2  CPU size: 01 byte, 10 word, 00 long, 11 line.
- A  in  23  CPU address A[23:1].
- FLASH_SPACE  in  1  address decode hit for flash.
- FLASH_RDY  in  1  flash ready/busy; high = ready.
- FLASH_TACK  in  1  one-clock word-complete pulse from the flash cycle machine.
- FL_TSn  out  1  word start strobe to the flash cycle machine, active low, one clock.
- FL_RnW  out  1  direction for the current word.
- FL_A  out  23  word address A[23:1] for the current word. FL_A[1]=0 selects D[31:16].
- CPU_TACK  out  1  one-clock pulse per completed CPU longword, or per byte/word transfer.
- CPU_TEA  out  1  one-clock transfer-error pulse.

## Operation
- Reset values: FL_TSn=1, FL_RnW=1, FL_A=0, CPU_TACK=0, CPU_TEA=0, state IDLE, both counters 0. RESET mid-transfer aborts to IDLE immediately with no acknowledge or error.
- States: IDLE, RDYWAIT, START, WAIT_ACK, GAP1, GAP2, ERR.
- IDLE: on TSn=0 && FLASH_SPACE=1, latch A, RnW and SIZ, and set the beat plan.
  - Line write (SIZ=11, RnW=0): go to ERR. No flash cycle is issued.
  - Other writes: go to RDYWAIT.
  - Reads: go to START.
- Beat plan:
  - Byte/word: one beat at A.
  - Long: two beats, {A[23:2],0} then {A[23:2],1}.
  - Line: eight beats. Start at the longword A[3:2] and wrap modulo 4 within A[23:4]. Within each longword, the hi word goes before the lo word.
- RDYWAIT (writes only): if FLASH_RDY=1, go to START. Otherwise increment the counter; at RDY_TIMEOUT, go to ERR. Reads never wait on FLASH_RDY, because status polling must work during busy.
- START: FL_TSn=0 for exactly this one clock, with FL_A and FL_RnW valid. Next state is WAIT_ACK. FL_A and FL_RnW stay stable until the next START.
- WAIT_ACK: on FLASH_TACK=1:
  - If this was the last word of a longword, or the only beat, pulse CPU_TACK on the next clock.
  - If it was the final beat, go to IDLE; otherwise go to GAP1.
  - If no FLASH_TACK arrives within ACK_TIMEOUT clocks, go to ERR.
- GAP1 → GAP2 → (RDYWAIT for writes / START for reads). The two gap clocks guarantee the flash machine has returned to its idle state before it samples the next FL_TSn.
- ERR: CPU_TEA=1 for one clock, then IDLE. If a long write errors after its first word, that word remains written; this is accepted.
- Ignored events:
  - TSn while not in IDLE.
  - TSn with FLASH_SPACE=0.
  - FLASH_TACK outside WAIT_ACK.
- CPU_TACK and CPU_TEA never assert in the same clock.

## Timing
Edge E0 is the one that samples TSn.
- Single read: START between E0 and E1; flash samples FL_TSn at E1; FLASH_TACK is high E2–E3; sampled at E3; CPU_TACK is high between E3 and E4.
- Read word period is 5 clocks (START to next START).
  - Long read: second START after E5, CPU_TACK after E8.
  - Line read: CPU_TACK after E8, E18, E28 and E38.
- Write, FLASH_RDY=1 throughout: RDYWAIT adds 1 clock per beat. Single write gives CPU_TACK after E4; long write gives CPU_TACK after E10.
- Busy wait extends the RDYWAIT dwell clock-for-clock.
- Line write: CPU_TEA is high between E1 and E2.
- Minimum spacing: FL_TSn low at most once per 5 clocks. The START of the next beat is never earlier than 3 clocks after the clock that sampled FLASH_TACK.

## Test plan
- Line read, A=0x000008 (A[3:2]=10), bench model of the flash machine: FL_A word sequence is 0x4,0x5,0x6,0x7,0x0,0x1,0x2,0x3 (A[23:1] units). Four CPU_TACK pulses occur after E8/E18/E28/E38, and there is no CPU_TEA.
- Long write, FLASH_RDY=1: two FL_TSn pulses 6 clocks apart, FL_RnW=0, one CPU_TACK after E10.
- Word write with FLASH_RDY=0 for 100 clocks: no FL_TSn while busy; START on the clock after FLASH_RDY rises; one CPU_TACK. Rerun with RDY_TIMEOUT=50 and FLASH_RDY held low: CPU_TEA pulse, no FL_TSn.
- Line write: CPU_TEA after E1, FL_TSn stays 1, no CPU_TACK.
- Byte read with the flash model suppressing FLASH_TACK: CPU_TEA after ACK_TIMEOUT clocks, then IDLE, and the next read completes normally.
- RESET asserted mid line read, during WAIT_ACK of beat 3: outputs return to reset values on the next clock. No CPU_TACK/CPU_TEA follows. The next TSn starts a fresh cycle.
